// File: rtl/qsquare_mult_pipe_if.sv
// Valid/ready operand and result bus of the quarter-square multiplier pipeline.
// The master drives operands and out_ready; the slave (the multiplier) returns results.
interface qsquare_mult_pipe_if #(
  parameter int W    = 16,
  parameter int FULL = 1
);
  localparam int OW = (FULL != 0) ? 2 * W : W;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] p;
  logic [1:0]    inflight;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, inflight
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, inflight
  );
endinterface

// File: rtl/qsquare_mult_pipe.sv
// Three-stage unsigned multiplier using the quarter-square identity
// a*b = ((a+b)^2 - (a-b)^2) / 4, with a single global stall on output backpressure.
module qsquare_mult_pipe #(
  parameter int W    = 16,
  parameter int FULL = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  qsquare_mult_pipe_if.slave  bus
);
  localparam int OW = (FULL != 0) ? 2 * W : W;

  logic            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [W:0]      sum_q, sum_d;
  logic [W-1:0]    diff_q, diff_d;
  logic [2*W+1:0]  sq_s_q, sq_s_d;
  logic [2*W-1:0]  sq_d_q, sq_d_d;
  logic [OW-1:0]   p_q, p_d;
  logic [1:0]      inflight_q, inflight_d;
  logic [2*W+1:0]  delta;
  logic            adv;

  // The whole pipe moves together: any free slot at the output lets every stage shift.
  assign adv = !v3_q || bus.out_ready;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    v1_d       = v1_q;
    v2_d       = v2_q;
    v3_d       = v3_q;
    sum_d      = sum_q;
    diff_d     = diff_q;
    sq_s_d     = sq_s_q;
    sq_d_d     = sq_d_q;
    p_d        = p_q;
    inflight_d = inflight_q;
    delta      = sq_s_q - {2'b00, sq_d_q};

    if (adv) begin
      v1_d       = bus.in_valid;
      v2_d       = v1_q;
      v3_d       = v2_q;
      sum_d      = {1'b0, bus.a} + {1'b0, bus.b};
      diff_d     = (bus.a >= bus.b) ? (bus.a - bus.b) : (bus.b - bus.a);
      sq_s_d     = {{(W+1){1'b0}}, sum_q} * {{(W+1){1'b0}}, sum_q};
      sq_d_d     = {{W{1'b0}}, diff_q} * {{W{1'b0}}, diff_q};
      // An empty stage 3 loads zero so p reads 0 whenever out_valid is low.
      p_d        = v2_q ? delta[OW+1:2] : '0;
      inflight_d = {1'b0, bus.in_valid} + {1'b0, v1_q} + {1'b0, v2_q};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: data registers are cleared along with the valid bits; the reset is synchronous so this costs no async fan-out.
    if (!rst_n) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      sum_q      <= '0;
      diff_q     <= '0;
      sq_s_q     <= '0;
      sq_d_q     <= '0;
      p_q        <= '0;
      inflight_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples its predecessor's pre-edge value.
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      sum_q      <= sum_d;
      diff_q     <= diff_d;
      sq_s_q     <= sq_s_d;
      sq_d_q     <= sq_d_d;
      p_q        <= p_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = v3_q;
  assign bus.p         = p_q;
  assign bus.inflight  = inflight_q;

  // (a+b)^2 - (a-b)^2 = 4ab: never negative and always a multiple of four.
  a_exact_quarter : assert property (
    @(posedge clk) disable iff (!rst_n)
    v2_q |-> ((sq_s_q >= {2'b00, sq_d_q}) && (delta[1:0] == 2'b00))
  );
endmodule

// File: tb/tb_qsquare_mult_pipe.sv
// Self-checking bench: full-width and low-half multipliers share one stimulus stream
// and are compared against a queue of expected a*b products.
module tb_qsquare_mult_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  always #5 clk = ~clk;

  qsquare_mult_pipe_if #(.W(W), .FULL(1)) bf ();
  qsquare_mult_pipe_if #(.W(W), .FULL(0)) bl ();

  assign bf.in_valid  = in_valid;
  assign bf.a         = a;
  assign bf.b         = b;
  assign bf.out_ready = out_ready;
  assign bl.in_valid  = in_valid;
  assign bl.a         = a;
  assign bl.b         = b;
  assign bl.out_ready = out_ready;

  qsquare_mult_pipe #(.W(W), .FULL(1)) dut_f (.clk(clk), .rst_n(rst_n), .bus(bf.slave));
  qsquare_mult_pipe #(.W(W), .FULL(0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bl.slave));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: products of accepted pairs, oldest first, not yet handed out.
  logic [31:0] exp_q[$];
  bit          chk_en = 1'b0;
  bit          held = 1'b0;
  logic [31:0] held_pf;
  logic [15:0] held_pl;

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", bf.in_ready, !bf.out_valid || out_ready);
      check("in_ready_low", bl.in_ready, bf.in_ready);
      check("out_valid_low", bl.out_valid, bf.out_valid);
      check("inflight", bf.inflight, 64'(exp_q.size()));
      check("inflight_low", bl.inflight, 64'(exp_q.size()));
      if (held) begin
        check("valid_hold", bf.out_valid, 1'b1);
        check("p_hold", bf.p, held_pf);
        check("p_hold_low", bl.p, held_pl);
      end
      if (bf.out_valid) begin
        check("spurious_out", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          check("p_full", bf.p, exp_q[0]);
          check("p_low", bl.p, exp_q[0][15:0]);
        end
      end else begin
        check("p_idle", bf.p, 0);
        check("p_idle_low", bl.p, 0);
      end
    end
    // Account for what the coming rising edge will do.
    if (!rst_n) begin
      exp_q.delete();
      chk_en = 1'b1;
      held   = 1'b0;
    end else if (chk_en) begin
      held    = bf.out_valid && !out_ready;
      held_pf = bf.p;
      held_pl = bl.p;
      if (bf.out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && bf.in_ready) exp_q.push_back(32'(a) * 32'(b));
    end
  end

  task automatic drive(input logic v, input logic [15:0] aa, input logic [15:0] bb, input logic rdy);
    @(posedge clk);
    #1;
    in_valid  = v;
    a         = aa;
    b         = bb;
    out_ready = rdy;
  endtask

  // Single pair into an empty pipe: invisible after two edges, present after three.
  task automatic single(input logic [15:0] aa, input logic [15:0] bb,
                        input logic [31:0] ef, input logic [15:0] el);
    drive(1'b1, aa, bb, 1'b1);
    @(negedge clk);
    check("single_accept", bf.in_ready, 1'b1);
    drive(1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    check("latency_early", bf.out_valid, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    check("latency_3", bf.out_valid, 1'b1);
    check("lit_full", bf.p, ef);
    check("lit_low", bl.p, el);
  endtask

  function automatic logic [15:0] rnd_op();
    logic [15:0] r;
    case ($urandom_range(0, 7))
      0:       r = 16'h0000;
      1:       r = 16'hFFFF;
      2:       r = 16'h8000;
      default: r = 16'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pa[8];
    logic [15:0] pb[8];
    logic [31:0] stall_p;
    int          idx;
    int          guard;

    rst_n = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_out_valid", bf.out_valid, 1'b0);
    check("rst_p", bf.p, 0);
    check("rst_inflight", bf.inflight, 0);
    check("rst_in_ready", bf.in_ready, 1'b1);

    single(16'd3, 16'd5, 32'h0000000F, 16'h000F);
    single(16'd5, 16'd3, 32'h0000000F, 16'h000F);
    single(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16'h0001);
    single(16'hFFFF, 16'h0000, 32'h00000000, 16'h0000);
    single(16'h8000, 16'h8000, 32'h40000000, 16'h0000);
    single(16'h0100, 16'h0100, 32'h00010000, 16'h0000);

    // Burst of 8 with the consumer stalled: pipe fills, then holds for 4 cycles.
    for (int i = 0; i < 8; i++) begin
      pa[i] = 16'($urandom);
      pb[i] = 16'($urandom);
    end
    idx = 0;
    guard = 0;
    do begin
      drive(1'b1, pa[idx], pb[idx], 1'b0);
      @(negedge clk);
      if (bf.in_ready) idx++;
      guard++;
    end while (bf.in_ready && guard < 10);
    check("fill_count", 64'(idx), 3);
    stall_p = bf.p;
    for (int s = 0; s < 4; s++) begin
      if (s > 0) begin
        drive(1'b1, pa[idx], pb[idx], 1'b0);
        @(negedge clk);
      end
      check("stall_in_ready", bf.in_ready, 1'b0);
      check("stall_inflight", bf.inflight, 3);
      check("stall_p", bf.p, stall_p);
      check("stall_p_first", bf.p, 32'(pa[0]) * 32'(pb[0]));
    end
    guard = 0;
    while (idx < 8 && guard < 30) begin
      drive(1'b1, pa[idx], pb[idx], 1'b1);
      @(negedge clk);
      if (bf.in_ready) idx++;
      guard++;
    end
    check("burst_all_accepted", 64'(idx), 8);
    repeat (5) drive(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    check("burst_drained", 64'(exp_q.size()), 0);

    // Reset with three results in flight; in_valid held high during reset.
    repeat (4) drive(1'b1, 16'h1234, 16'h5678, 1'b0);
    @(negedge clk);
    check("pre_rst_inflight", bf.inflight, 3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", bf.out_valid, 1'b0);
    check("midrst_p", bf.p, 0);
    check("midrst_inflight", bf.inflight, 0);
    check("midrst_in_ready", bf.in_ready, 1'b1);
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, '0, '0, 1'b1);
      @(negedge clk);
      check("post_rst_quiet", bf.out_valid, 1'b0);
    end

    // Random traffic with random valid and backpressure.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), $urandom_range(0, 3) != 0);
    end

    drive(1'b0, '0, '0, 1'b1);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("final_drain", 64'(exp_q.size()), 0);
    @(negedge clk);
    check("final_idle", bf.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
